mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM register output (execute_data_t).
//  Issues load/store transactions on the data bus (dbus) and holds the pipe via stall until the bus completes.
//  Aligns, sign- or zero-extends load data and registers the result as memory_data_t for the MEM/WB register.
//  Non-memory instructions pass through with 1-cycle latency.
// PARAMETERS
//  XLEN    64  data width; dreq_data, dresp_data and load results are XLEN bits
//  ADDR_W  64  address width
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           asynchronous, active-low; 0 = reset
//  in_valid     in   1           in_data holds a live instruction
//  in_data      in   execute_data_t  EX/MEM payload; upstream holds it stable while stall=1
//  stall        out  1           freeze IF..EX/MEM; combinational
//  dreq_valid   out  1           dbus request valid
//  dreq_addr    out  ADDR_W      byte address
//  dreq_size    out  2           0=B 1=H 2=W 3=D
//  dreq_strobe  out  XLEN/8      byte-write enables; all zero for loads
//  dreq_data    out  XLEN        store data, lane-aligned
//  dresp_ok     in   1           transaction complete; one pulse per request
//  dresp_data   in   XLEN        load data, full aligned word
//  out_valid    out  1           out_data valid this cycle
//  out_data     out  memory_data_t  result for MEM/WB
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - state=IDLE
//   - dreq_valid=0, out_valid=0, out_data='0
//   - all latched request registers cleared
//  FSM states:
//   - IDLE: accepts an instruction when in_valid=1.
//   - BUSY: dreq_valid=1. addr, size, strobe and data come from the latched registers and are stable until dresp_ok.
//  Non-memory op (neither mem_read nor mem_write):
//   - out_valid<=1 and out_data<=pass-through at the next edge; stall=0.
//  Misaligned op (addr[2:0] not a multiple of 1<<mem_size):
//   - No bus request.
//   - Next edge: out_valid<=1, out_data.misaligned<=1, result<=0.
//   - stall=0.
//  Aligned memory op in IDLE (cycle T0):
//   - stall=1 combinationally.
//   - Latch the request; state->BUSY at T1.
//  BUSY:
//   - stall = !dresp_ok.
//   - If dresp_ok at cycle Tk (k>=1): state->IDLE, out_valid=1 at Tk+1 carrying the result.
//   - While in BUSY, in_valid/in_data are ignored. This also covers the still-held op during Tk.
//  Latency:
//   - Non-memory and misaligned ops: 1 cycle.
//   - Memory ops: 1 + bus wait. A 0-wait bus (dresp_ok during T1) gives out_valid at T2.
//  Store formatting:
//   - dreq_data = wdata replicated across lanes per size.
//   - dreq_strobe = size mask << addr[2:0]. Example: H at addr 0x6 -> strobe 8'hC0.
//  Load formatting:
//   - Shift dresp_data right by addr[2:0]*8, truncate to size.
//   - Sign-extend unless mem_unsigned.
//  out_valid:
//   - 0 in every cycle not listed above. A stalled or empty slot gives a bubble with out_data.valid=0.
//  Boundary cases:
//   - Stray dresp_ok in IDLE: ignored, no output.
//   - reset asserted mid-BUSY: request dropped immediately (dreq_valid=0). A later stray dresp_ok is ignored.
//   - Back-to-back memory ops: the second is accepted in the IDLE cycle Tk+1. There is no dead cycle beyond the state return.
// STRUCTURE
//  Package pipes gets:
//   - execute_data_t fields: valid, mem_read, mem_write, mem_size[1:0], mem_unsigned, addr, wdata.
//   - memory_data_t: execute_data_t fields plus result and misaligned.
//  Package common gets:
//   - msize_t enum: MSIZE1/2/4/8.
//   - dbus request/response structs.
//  Sub-module mem_align (combinational):
//   - Store lane replication and strobe generation.
//   - Load extract and extend.
//   - Shared by formatting code; the FSM stays in mem_access_unit.
// TESTING
//  1. ALU op, in_valid=1 -> out_valid=1 next cycle, out_data equals input, stall never asserted.
//  2. LD 0x1000, dresp_ok 3 cycles after dreq_valid, data 0x1122334455667788 -> stall 4 cycles, result 0x1122334455667788.
//  3. LB 0x1003 (signed), dresp_data 0x00000000_80000000 -> result 0xFFFF_FFFF_FFFF_FF80. LBU gives 0x80.
//  4. SH 0x1006, wdata 0xBEEF, 0-wait bus -> dreq_strobe 8'hC0, dreq_data[63:48]=0xBEEF, out_valid at T2.
//  5. LW 0x1002 (misaligned) -> dreq_valid never 1, out_valid next cycle, misaligned=1.
//  6. reset=0 during BUSY, then stray dresp_ok after release -> dreq_valid drops at once, no out_valid, next op is served normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM stage: pipeline payloads (EX/MEM and MEM/WB),
// access-size encoding, data-bus request/response records and small helpers.
package mem_access_unit_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned STRB_W = XLEN / 8;

    // ---- common ----
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [XLEN-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic            ok;
        logic [XLEN-1:0] data;
    } dbus_resp_t;

    // ---- pipes ----
    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              mem_write;
        msize_t            mem_size;
        logic              mem_unsigned;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } execute_data_t;

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              mem_write;
        msize_t            mem_size;
        logic              mem_unsigned;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
        logic [XLEN-1:0]   result;
        logic              misaligned;
    } memory_data_t;

    // Natural alignment: the low address bits below the access size must be zero.
    function automatic logic is_misaligned(msize_t size, logic [2:0] offset);
        logic mis;
        case (size)
            MSIZE1:  mis = 1'b0;
            MSIZE2:  mis = offset[0];
            MSIZE4:  mis = |offset[1:0];
            default: mis = |offset;
        endcase
        return mis;
    endfunction

    // Carry the EX/MEM fields forward; result and misaligned start cleared.
    function automatic memory_data_t to_mem(execute_data_t e);
        memory_data_t m;
        m              = '0;
        m.valid        = e.valid;
        m.mem_read     = e.mem_read;
        m.mem_write    = e.mem_write;
        m.mem_size     = e.mem_size;
        m.mem_unsigned = e.mem_unsigned;
        m.addr         = e.addr;
        m.wdata        = e.wdata;
        return m;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// MEM-stage signal bundle: EX/MEM input, stall, data-bus request/response and
// MEM/WB output. slave = the MEM unit, master = the pipeline/bus environment.
interface mem_access_if
    import mem_access_unit_pkg::*;
();
    logic                in_valid;
    execute_data_t       in_data;
    logic                stall;
    logic                dreq_valid;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [1:0]          dreq_size;
    logic [STRB_W-1:0]   dreq_strobe;
    logic [XLEN-1:0]     dreq_data;
    logic                dresp_ok;
    logic [XLEN-1:0]     dresp_data;
    logic                out_valid;
    memory_data_t        out_data;

    modport slave (
        input  in_valid, in_data, dresp_ok, dresp_data,
        output stall, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output out_valid, out_data
    );

    modport master (
        output in_valid, in_data, dresp_ok, dresp_data,
        input  stall, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  out_valid, out_data
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane formatting for the data bus.
//   size_i/offset_i       access size and addr[2:0]
//   is_write_i            store: strobe active; load: strobe all zero
//   is_unsigned_i         zero-extend loads instead of sign-extending
//   wdata_i -> wdata_o    store data replicated across lanes
//   strobe_o              size mask shifted to the byte offset
//   rdata_i -> rdata_o    load word shifted down, truncated and extended
module mem_align
    import mem_access_unit_pkg::*;
(
    input  msize_t            size_i,
    input  logic [2:0]        offset_i,
    input  logic              is_write_i,
    input  logic              is_unsigned_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [STRB_W-1:0] strobe_o,
    output logic [XLEN-1:0]   rdata_o
);
    logic [STRB_W-1:0] mask;
    logic [XLEN-1:0]   shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        mask    = '1;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (size_i)
            MSIZE1: begin
                mask    = 8'h01;
                wdata_o = {8{wdata_i[7:0]}};
                rdata_o = {{(XLEN-8){shifted[7] & ~is_unsigned_i}}, shifted[7:0]};
            end
            MSIZE2: begin
                mask    = 8'h03;
                wdata_o = {4{wdata_i[15:0]}};
                rdata_o = {{(XLEN-16){shifted[15] & ~is_unsigned_i}}, shifted[15:0]};
            end
            MSIZE4: begin
                mask    = 8'h0F;
                wdata_o = {2{wdata_i[31:0]}};
                rdata_o = {{(XLEN-32){shifted[31] & ~is_unsigned_i}}, shifted[31:0]};
            end
            default: ;
        endcase
        strobe_o = is_write_i ? (mask << offset_i) : '0;
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues load/store on the data bus, stalls the pipe until the bus
// responds, formats load data and registers a memory_data_t for MEM/WB.
// Non-memory and misaligned ops complete in one cycle without a bus request.
//   clk_i     rising-edge clock
//   reset_ni  asynchronous active-low reset
//   bus       mem_access_if.slave (EX/MEM in, stall, dbus req/resp, MEM/WB out)
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input logic         clk_i,
    input logic         reset_ni,
    mem_access_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    execute_data_t op_q, op_d;
    logic          out_valid_q, out_valid_d;
    memory_data_t  out_data_q, out_data_d;

    logic              in_mem_op, in_misaligned, accept_mem;
    logic              stall;
    dbus_req_t         req;
    dbus_resp_t        resp;
    logic [XLEN-1:0]   store_data, load_data;
    logic [STRB_W-1:0] strobe;

    assign in_mem_op     = bus.in_data.mem_read | bus.in_data.mem_write;
    assign in_misaligned = in_mem_op & is_misaligned(bus.in_data.mem_size, bus.in_data.addr[2:0]);
    assign accept_mem    = bus.in_valid & in_mem_op & ~in_misaligned;
    assign resp          = '{ok: bus.dresp_ok, data: bus.dresp_data};

    // Formatting works off the latched op so the request stays stable in BUSY.
    mem_align u_align (
        .size_i        (op_q.mem_size),
        .offset_i      (op_q.addr[2:0]),
        .is_write_i    (op_q.mem_write),
        .is_unsigned_i (op_q.mem_unsigned),
        .wdata_i       (op_q.wdata),
        .rdata_i       (resp.data),
        .wdata_o       (store_data),
        .strobe_o      (strobe),
        .rdata_o       (load_data)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept_mem) state_d = StBusy;
            StBusy:  if (resp.ok)    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // In BUSY the input slot is ignored, including the op still held during the
    // dresp_ok cycle; IDLE only looks at in_data again one cycle later.
    always_comb begin
        stall       = 1'b0;
        req         = '0;
        op_d        = op_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        case (state_q)
            StIdle: begin
                stall = accept_mem;
                if (accept_mem) begin
                    op_d = bus.in_data;
                end else if (bus.in_valid) begin
                    out_valid_d           = 1'b1;
                    out_data_d            = to_mem(bus.in_data);
                    out_data_d.misaligned = in_misaligned;
                end
            end
            StBusy: begin
                stall      = ~resp.ok;
                req.valid  = 1'b1;
                req.addr   = op_q.addr;
                req.size   = op_q.mem_size;
                req.strobe = strobe;
                req.data   = store_data;
                if (resp.ok) begin
                    out_valid_d = 1'b1;
                    out_data_d  = to_mem(op_q);
                    if (op_q.mem_read) out_data_d.result = load_data;
                end
            end
            default: ;
        endcase
    end

    assign bus.stall       = stall;
    assign bus.dreq_valid  = req.valid;
    assign bus.dreq_addr   = req.addr;
    assign bus.dreq_size   = req.size;
    assign bus.dreq_strobe = req.strobe;
    assign bus.dreq_data   = req.data;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
endmodule
